// File: rtl/xor_unit_pkg.sv
// Shared definitions for the XOR frame unit: mode encodings and the per-lane operator.
// Latency: none (pure types and functions).
// Backpressure: not applicable.
package xor_unit_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_XOR   = 2'b00;
    localparam mode_t MODE_XNOR  = 2'b01;
    localparam mode_t MODE_ACCUM = 2'b10;
    localparam mode_t MODE_RSVD  = 2'b11;

    // One lane of the bank. The reserved encoding falls through to plain XOR.
    function automatic logic lane_op(
        input mode_t mode,
        input logic  a,
        input logic  b,
        input logic  acc
    );
        logic x;
        x = a ^ b;
        case (mode)
            MODE_XNOR:  return ~x;
            MODE_ACCUM: return acc ^ x;
            default:    return x;
        endcase
    endfunction

endpackage

// File: rtl/xor_out_stage.sv
// Single registered output slot carrying result data, its parity and the frame-last flag.
// Latency: 1 clk from load to out_valid.
// Backpressure: contents hold while out_valid && !out_ready; in_ready drops only in that case.
module xor_out_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_last
);

    // The slot can take a new beat when it is empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;

    // Capture on load; otherwise empty the slot once downstream has taken it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_last   <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= load_data;
            out_parity <= ^load_data;
            out_last   <= load_last;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/xor_frame_unit.sv
// WIDTH-lane XOR/XNOR/accumulate bank with frame-level mode latching, parity and frame counting.
// Latency: 1 clk from accepted beat to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds and blocks new beats.
module xor_frame_unit
    import xor_unit_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_last,
    output logic             mode_err,
    output logic [CNT_W-1:0] frame_cnt
);

    logic             accept;
    logic             deliver;
    logic             mid_frame;
    mode_t            mode_q;
    mode_t            eff_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result;

    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    // The first beat of a frame selects the mode; later beats follow the latched one.
    assign eff_mode = mid_frame ? mode_q : mode_t'(in_mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign result[i] = lane_op(eff_mode, in_a[i], in_b[i], acc[i]);
    end

    // Frame tracking: latch mode on the opening beat, flag disagreeing beats for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_frame <= 1'b0;
            mode_q    <= MODE_XOR;
            mode_err  <= 1'b0;
        end else begin
            mode_err <= accept && mid_frame && (mode_t'(in_mode) != mode_q);
            if (accept) begin
                if (!mid_frame) begin
                    mode_q <= mode_t'(in_mode);
                end
                mid_frame <= !in_last;
            end
        end
    end

    // Running XOR: only ACCUM beats fold in, and any frame end clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            if (in_last) begin
                acc <= '0;
            end else if (eff_mode == MODE_ACCUM) begin
                acc <= result;
            end
        end
    end

    // Count frames as their final result leaves the unit; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (deliver && out_last) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    xor_out_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_data  (result),
        .load_last  (in_last),
        .out_ready  (out_ready),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_last   (out_last)
    );

endmodule

// File: tb/tb_xor_frame_unit.sv
// Self-checking bench for xor_frame_unit: table-driven beats feed a scoreboard queue,
// a negedge monitor pops and compares delivered results, frame_cnt and mode_err.
// Hand sequences cover backpressure, reset mid-frame and counter wrap (CNT_W=2).
module tb_xor_frame_unit;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_mode;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic             out_last;
    logic             mode_err;
    logic [CNT_W-1:0] frame_cnt;

    xor_frame_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_last   (out_last),
        .mode_err   (mode_err),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] mode;
        logic       last;
        logic [3:0] d;
        logic       p;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0] d;
        logic       p;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [3:0] cur_d;
    logic       cur_p;
    logic       cur_err;
    logic       err_exp  = 1'b0;
    logic [1:0] fc_exp   = 2'd0;
    logic       fc_pend  = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Monitor: all DUT signals are stable at the negedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            err_exp = 1'b0;
            fc_exp  = 2'd0;
            fc_pend = 1'b0;
        end else begin
            fc_exp  = fc_exp + {1'b0, fc_pend};
            fc_pend = 1'b0;
            check("frame_cnt", 32'(frame_cnt), 32'(fc_exp));
            check("mode_err", 32'(mode_err), 32'(err_exp));
            err_exp = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_parity", 32'(out_parity), 32'(e.p));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
                if (out_last) fc_pend = 1'b1;
            end
            if (in_valid && in_ready) begin
                e.d = cur_d; e.p = cur_p; e.last = in_last;
                sb.push_back(e);
                err_exp = cur_err;
            end
        end
    end

    // Present a beat and hold it until it is accepted (bounded wait).
    task automatic send(input vec_t v);
        bit ok;
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_mode  = v.mode;
        in_last  = v.last;
        cur_d    = v.d;
        cur_p    = v.p;
        cur_err  = v.err;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: beat a=%b b=%b never accepted", v.a, v.b);
        end
    endtask

    // Idle cycles with garbage on the operands to show it is ignored.
    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_a    = 4'($urandom);
            in_b    = 4'($urandom);
            in_mode = 2'($urandom);
            in_last = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_parity", 32'(out_parity), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_mode_err", 32'(mode_err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t main_tbl[11];
    vec_t post_rst[2];
    vec_t b1, b2, partial, single;
    int   c0;

    initial begin
        main_tbl[0]  = '{4'b1010, 4'b0110, 2'b00, 1'b1, 4'b1100, 1'b0, 1'b0}; // XOR
        main_tbl[1]  = '{4'b0001, 4'b0000, 2'b01, 1'b1, 4'b1110, 1'b1, 1'b0}; // XNOR
        main_tbl[2]  = '{4'b0001, 4'b0010, 2'b10, 1'b0, 4'b0011, 1'b0, 1'b0}; // ACCUM 1
        main_tbl[3]  = '{4'b0100, 4'b0000, 2'b10, 1'b0, 4'b0111, 1'b1, 1'b0}; // ACCUM 2
        main_tbl[4]  = '{4'b1000, 4'b0001, 2'b10, 1'b1, 4'b1110, 1'b1, 1'b0}; // ACCUM last
        main_tbl[5]  = '{4'b0001, 4'b0000, 2'b10, 1'b1, 4'b0001, 1'b1, 1'b0}; // acc cleared
        main_tbl[6]  = '{4'b0011, 4'b0101, 2'b00, 1'b0, 4'b0110, 1'b0, 1'b0}; // XOR opens
        main_tbl[7]  = '{4'b1111, 4'b0000, 2'b01, 1'b0, 4'b1111, 1'b0, 1'b1}; // mode err, still XOR
        main_tbl[8]  = '{4'b0001, 4'b0001, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0};
        main_tbl[9]  = '{4'b1100, 4'b1010, 2'b11, 1'b1, 4'b0110, 1'b0, 1'b0}; // reserved = XOR
        main_tbl[10] = '{4'b0110, 4'b1001, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b0}; // XNOR all ones -> 0
        post_rst[0]  = '{4'b0110, 4'b0011, 2'b00, 1'b1, 4'b0101, 1'b0, 1'b0};
        post_rst[1]  = '{4'b0001, 4'b0000, 2'b10, 1'b1, 4'b0001, 1'b1, 1'b0};
        b1      = '{4'b1001, 4'b0011, 2'b00, 1'b1, 4'b1010, 1'b0, 1'b0};
        b2      = '{4'b0111, 4'b0000, 2'b00, 1'b1, 4'b0111, 1'b1, 1'b0};
        partial = '{4'b0001, 4'b0010, 2'b10, 1'b0, 4'b0011, 1'b0, 1'b0};
        single  = '{4'b0101, 4'b0011, 2'b00, 1'b1, 4'b0110, 1'b0, 1'b0};

        in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_last = 1'b0;
        out_ready = 1'b1; cur_d = '0; cur_p = 1'b0; cur_err = 1'b0;
        do_reset();
        idle(2);

        // Back-to-back table with out_ready high: one accept per clock.
        c0 = cyc;
        foreach (main_tbl[i]) send(main_tbl[i]);
        check("throughput_cycles", 32'(cyc - c0), 32'd11);
        idle(3);

        // Backpressure: result held, second beat blocked for 3 clocks.
        out_ready = 1'b0;
        send(b1);
        fork
            send(b2);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_hold_data", 32'(out_data), 32'(b1.d));
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        idle(3);
        check("drain_empty", 32'(sb.size()), 32'd0);

        // Reset with an open ACCUM frame and a stalled result pending.
        out_ready = 1'b0;
        send(partial);
        in_valid = 1'b0;
        do_reset();
        out_ready = 1'b1;
        idle(1);
        foreach (post_rst[i]) send(post_rst[i]);
        idle(3);

        // Counter wrap: 5 frames with a 2-bit counter lands on 1.
        do_reset();
        idle(1);
        for (int i = 0; i < 5; i++) send(single);
        idle(3);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd1);
        check("final_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/xor_frame_unit.md
Name: xor_frame_unit

Overview:
- Parametrised, clocked successor to the quad 2-input XOR gate: a WIDTH-bit bank of XOR/XNOR lanes with a one-stage registered output and valid/ready handshakes on both sides.
- Adds a frame-based accumulate mode (running XOR across beats), output parity, a frame counter and mode-consistency checking.
- Sits between a stimulus/data source and downstream logic as the first sequential gate-level building block in the design.

Parameters:
- WIDTH, 4, number of XOR lanes (operand and result width).
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_mode  in  2  00 XOR, 01 XNOR, 10 ACCUM, 11 reserved (treated as XOR).
- in_last  in  1  final beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  result.
- out_parity  out  1  reduction XOR of out_data.
- out_last  out  1  result is final beat of frame.
- mode_err  out  1  one-cycle pulse: in_mode differed from the frame's latched mode.
- frame_cnt  out  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_parity=0, out_last=0, mode_err=0, frame_cnt=0; accumulator=0, mid_frame=0, latched mode=00. in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
  - out_* hold stable while out_valid && !out_ready.
  - Accept and deliver in the same cycle sustain full throughput, one beat per clock.
- Latency: result registered exactly 1 clk after accept.
- Mode latching:
  - On an accepted beat with mid_frame=0, the effective mode is in_mode; it is latched and mid_frame is set to 1.
  - While mid_frame=1, the latched mode is used. If in_mode differs from the latched mode, mode_err pulses for 1 clk and the beat is still processed with the latched mode.
  - An accepted beat with in_last=1 clears mid_frame. A single-beat frame (first beat also last) is legal.
- Datapath per accepted beat, with x = in_a ^ in_b:
  - XOR/11: out_data = x.
  - XNOR: out_data = ~x.
  - ACCUM: out_data = acc ^ x; acc <= acc ^ x.
- Accumulator:
  - An accepted beat with in_last=1 clears acc to 0, regardless of mode.
  - acc is unchanged in XOR/XNOR modes.
- Result flags: out_parity = ^out_data, registered with out_data. out_last = in_last of the same beat.
- frame_cnt increments when out_last is delivered; wraps from 2^CNT_W-1 to 0.
- out_valid: set on accept; cleared on a deliver that has no simultaneous accept.
- Boundaries:
  - in_valid asserted with in_ready=0 consumes nothing; the source must hold the beat.
  - Reset mid-frame discards the frame: acc=0, mid_frame=0, pending output dropped.
  - X on in_a/in_b while in_valid=0 has no effect.

Decomposition:
- Package xor_unit_pkg: mode constants MODE_XOR=2'b00, MODE_XNOR=2'b01, MODE_ACCUM=2'b10, MODE_RSVD=2'b11, and a function lane_op(mode, a, b, acc).
- Sub-module xor_out_stage: the registered valid/ready output stage (data, parity, last) with hold-on-stall.
- Top level holds mode/mid_frame control, acc and frame_cnt.

Test Plan:
- Reset: rst_n=0 mid-traffic -> all outputs 0 immediately, in_ready=1 after release, frame_cnt=0.
- XOR single-beat frame: a=1010, b=0110, mode 00, last=1 -> next clk out_data=1100, out_parity=0, out_last=1; frame_cnt=1 after deliver.
- XNOR: a=0001, b=0000, mode 01, last=1 -> out_data=1110, out_parity=1.
- ACCUM frame: beats (0001,0010), (0100,0000), (1000,0001 last), mode 10 -> out_data 0011, 0111, 1110 with out_parity 0, 1, 1. Next frame beat (0001,0000) -> 0001, confirming acc cleared.
- Backpressure: out_ready=0 for 3 clk with out_valid=1 -> in_ready=0 and out_data held. Second beat not consumed until release; both results delivered in order with no loss or duplication. Back-to-back with out_ready=1 -> one result per clk.
- Mode error and wrap:
  - Frame opens with mode 00; beat 2 has mode 01 -> processed as XOR, mode_err=1 for exactly 1 clk.
  - With CNT_W=2, 5 frames -> frame_cnt=1.
